// File: rtl/alu_scheduler.sv
// Round-robin scheduler sharing one external ALU among four requesters (IDLE -> ISSUE -> RESP).
// Optional per-requester carry chaining is enabled with `define ALU_SCHEDULER_CARRY_CHAIN_EN.
module alu_scheduler #(
   parameter int WIDTH       = 32,
   parameter int OPCODE      = 4,
   parameter int REGS_CODING = 3,
   parameter int FLAGS       = 4,
   parameter int CARRY       = 0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [3:0]               req,
   input  logic [4*OPCODE-1:0]      req_opcode,
   input  logic [4*WIDTH-1:0]       req_op1,
   input  logic [4*WIDTH-1:0]       req_op2,
   input  logic [4*REGS_CODING-1:0] req_dest,
   input  logic [3:0]               req_cin,
   output logic [3:0]               gnt,
   output logic [3:0]               rsp_valid,
   output logic [WIDTH-1:0]         rsp_result,
   output logic [FLAGS-1:0]         rsp_flags,
   output logic [REGS_CODING-1:0]   rsp_dest,
   output logic                     busy,
   output logic                     alu_en,
   output logic [OPCODE-1:0]        alu_opcode,
   output logic [WIDTH-1:0]         alu_op1,
   output logic [WIDTH-1:0]         alu_op2,
   output logic                     alu_cin,
   output logic [REGS_CODING-1:0]   alu_dest_in,
   input  logic [WIDTH-1:0]         alu_result,
   input  logic [FLAGS-1:0]         alu_flags,
   input  logic [REGS_CODING-1:0]   alu_dest_out
);

   // state | meaning
   // IDLE  | waiting for any req; grant and latch operands in the same cycle
   // ISSUE | alu_en high, ALU evaluates latched operands
   // RESP  | rsp_valid pulse to the granted requester
   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t                 state;
   logic [1:0]             last_gnt;
   logic [OPCODE-1:0]      issue_opcode;
   logic [WIDTH-1:0]       issue_op1;
   logic [WIDTH-1:0]       issue_op2;
   logic [REGS_CODING-1:0] issue_dest;
   logic [1:0]             pick_idx;
   logic [1:0]             cand;
   logic                   pick_hit;

`ifdef ALU_SCHEDULER_CARRY_CHAIN_EN
   logic [3:0]             carry_reg;
`else
   logic                   issue_cin;
`endif

   // Round-robin search beginning just after the last granted requester
   always_comb begin
      pick_idx = last_gnt;
      pick_hit = 1'b0;
      cand     = last_gnt;
      for (int k = 1; k <= 4; k++) begin
         cand = last_gnt + 2'(k);
         if (!pick_hit && req[cand]) begin
            pick_idx = cand;
            pick_hit = 1'b1;
         end
      end
   end

   assign gnt  = (rst_n && state == IDLE && pick_hit) ? (4'b0001 << pick_idx) : 4'b0000;
   assign busy = (state != IDLE);

   assign alu_opcode  = issue_opcode;
   assign alu_op1     = issue_op1;
   assign alu_op2     = issue_op2;
   assign alu_dest_in = issue_dest;
`ifdef ALU_SCHEDULER_CARRY_CHAIN_EN
   assign alu_cin = carry_reg[last_gnt];
`else
   assign alu_cin = issue_cin;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         last_gnt     <= 2'd3;
         rsp_valid    <= '0;
         alu_en       <= 1'b0;
         issue_opcode <= '0;
         issue_op1    <= '0;
         issue_op2    <= '0;
         issue_dest   <= '0;
         rsp_result   <= '0;
         rsp_flags    <= '0;
         rsp_dest     <= '0;
`ifdef ALU_SCHEDULER_CARRY_CHAIN_EN
         carry_reg    <= '0;
`else
         issue_cin    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               rsp_valid <= '0;
               if (pick_hit) begin
                  issue_opcode <= req_opcode[int'(pick_idx)*OPCODE +: OPCODE];
                  issue_op1    <= req_op1[int'(pick_idx)*WIDTH +: WIDTH];
                  issue_op2    <= req_op2[int'(pick_idx)*WIDTH +: WIDTH];
                  issue_dest   <= req_dest[int'(pick_idx)*REGS_CODING +: REGS_CODING];
`ifndef ALU_SCHEDULER_CARRY_CHAIN_EN
                  issue_cin    <= req_cin[pick_idx];
`endif
                  last_gnt     <= pick_idx;
                  alu_en       <= 1'b1;
                  state        <= ISSUE;
               end
            end
            ISSUE: begin
               alu_en     <= 1'b0;
               rsp_result <= alu_result;
               rsp_flags  <= alu_flags;
               rsp_dest   <= alu_dest_out;
               rsp_valid  <= 4'b0001 << last_gnt;
`ifdef ALU_SCHEDULER_CARRY_CHAIN_EN
               carry_reg[last_gnt] <= alu_flags[CARRY];
`endif
               state      <= RESP;
            end
            RESP: begin
               rsp_valid <= '0;
               state     <= IDLE;
            end
            default: begin
               alu_en    <= 1'b0;
               rsp_valid <= '0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_scheduler.sv
// Directed bench for alu_scheduler with a small behavioural ALU (add, add-with-carry, xor).
module tb_alu_scheduler;
   localparam int WIDTH = 32;
   localparam int OPCODE = 4;
   localparam int REGS_CODING = 3;
   localparam int FLAGS = 4;

   logic                     clk = 1'b0;
   logic                     rst_n;
   logic [3:0]               req;
   logic [4*OPCODE-1:0]      req_opcode;
   logic [4*WIDTH-1:0]       req_op1;
   logic [4*WIDTH-1:0]       req_op2;
   logic [4*REGS_CODING-1:0] req_dest;
   logic [3:0]               req_cin;
   logic [3:0]               gnt;
   logic [3:0]               rsp_valid;
   logic [WIDTH-1:0]         rsp_result;
   logic [FLAGS-1:0]         rsp_flags;
   logic [REGS_CODING-1:0]   rsp_dest;
   logic                     busy;
   logic                     alu_en;
   logic [OPCODE-1:0]        alu_opcode;
   logic [WIDTH-1:0]         alu_op1;
   logic [WIDTH-1:0]         alu_op2;
   logic                     alu_cin;
   logic [REGS_CODING-1:0]   alu_dest_in;
   logic [WIDTH-1:0]         alu_result = '0;
   logic [FLAGS-1:0]         alu_flags = '0;
   logic [REGS_CODING-1:0]   alu_dest_out = '0;

   int n_pass = 0;
   int n_total = 0;
   logic carry_exp;

   alu_scheduler #(.WIDTH(WIDTH), .OPCODE(OPCODE), .REGS_CODING(REGS_CODING),
                   .FLAGS(FLAGS), .CARRY(0)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_opcode(req_opcode),
      .req_op1(req_op1), .req_op2(req_op2), .req_dest(req_dest), .req_cin(req_cin),
      .gnt(gnt), .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_flags(rsp_flags),
      .rsp_dest(rsp_dest), .busy(busy), .alu_en(alu_en), .alu_opcode(alu_opcode),
      .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_cin(alu_cin), .alu_dest_in(alu_dest_in),
      .alu_result(alu_result), .alu_flags(alu_flags), .alu_dest_out(alu_dest_out)
   );

   always #5 clk = ~clk;

   // ALU updates on the falling edge in the middle of ISSUE
   always @(negedge clk) begin
      logic [WIDTH:0] s;
      if (alu_en) begin
         case (alu_opcode)
            4'b0000: s = {1'b0, alu_op1} + {1'b0, alu_op2};
            4'b0001: s = {1'b0, alu_op1} + {1'b0, alu_op2} + {{WIDTH{1'b0}}, alu_cin};
            default: s = {1'b0, alu_op1 ^ alu_op2};
         endcase
         alu_result   = s[WIDTH-1:0];
         alu_flags    = {2'b00, (s[WIDTH-1:0] == '0), s[WIDTH]};
         alu_dest_out = alu_dest_in;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic drive_pt();
      @(posedge clk);
      #1;
   endtask

   task automatic sample_pt();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req   = 4'b0000;
      drive_pt();
      drive_pt();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; req = '0; req_opcode = '0; req_op1 = '0; req_op2 = '0;
      req_dest = '0; req_cin = '0;

      // reset state, with a request pending to prove gnt stays low in reset
      drive_pt();
      req = 4'b1111;
      drive_pt();
      sample_pt();
      check("rst_gnt", gnt, 4'b0000);
      check("rst_rsp_valid", rsp_valid, 4'b0000);
      check("rst_alu_en", alu_en, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_result", rsp_result, 32'd0);
      check("rst_alu_op1", alu_op1, 32'd0);

      // single requester 2: 5 + 7
      do_reset();
      req = 4'b0100;
      req_opcode[2*OPCODE +: OPCODE] = 4'b0000;
      req_op1[2*WIDTH +: WIDTH] = 32'd5;
      req_op2[2*WIDTH +: WIDTH] = 32'd7;
      req_dest[2*REGS_CODING +: REGS_CODING] = 3'd5;
      sample_pt();
      check("s2_gnt_N", gnt, 4'b0100);
      check("s2_busy_N", busy, 1'b0);
      drive_pt();
      req = 4'b0000;
      sample_pt();
      check("s2_gnt_N1", gnt, 4'b0000);
      check("s2_alu_en_N1", alu_en, 1'b1);
      check("s2_busy_N1", busy, 1'b1);
      check("s2_alu_op1", alu_op1, 32'd5);
      check("s2_alu_op2", alu_op2, 32'd7);
      check("s2_alu_dest", alu_dest_in, 3'd5);
      drive_pt();
      sample_pt();
      check("s2_alu_en_N2", alu_en, 1'b0);
      check("s2_rsp_valid_N2", rsp_valid, 4'b0100);
      check("s2_result", rsp_result, 32'd12);
      check("s2_dest", rsp_dest, 3'd5);
      check("s2_flags", rsp_flags, 4'b0000);
      drive_pt();
      sample_pt();
      check("s2_rsp_valid_N3", rsp_valid, 4'b0000);
      check("s2_busy_N3", busy, 1'b0);
      check("s2_result_hold", rsp_result, 32'd12);

      // all four requesting: grants 0,1,2,3 every 3 cycles; requester i computes 10*i + 1
      do_reset();
      for (int i = 0; i < 4; i++) begin
         req_opcode[i*OPCODE +: OPCODE] = 4'b0000;
         req_op1[i*WIDTH +: WIDTH] = 32'(10 * i);
         req_op2[i*WIDTH +: WIDTH] = 32'd1;
         req_dest[i*REGS_CODING +: REGS_CODING] = 3'(i + 1);
      end
      req = 4'b1111;
      for (int c = 0; c < 12; c++) begin
         if (c > 0) drive_pt();
         sample_pt();
         check($sformatf("rr_gnt_c%0d", c), gnt,
               (c % 3 == 0) ? (64'd1 << (c / 3)) : 64'd0);
         check($sformatf("rr_rsp_valid_c%0d", c), rsp_valid,
               (c % 3 == 2) ? (64'd1 << (c / 3)) : 64'd0);
         if (c % 3 == 2) begin
            check($sformatf("rr_result_c%0d", c), rsp_result, 64'(10 * (c / 3) + 1));
            check($sformatf("rr_dest_c%0d", c), rsp_dest, 64'(c / 3 + 1));
         end
      end

      // req[1] raised while requester 0 is in ISSUE must wait for IDLE
      do_reset();
      req = 4'b0001;
      sample_pt();
      check("late_gnt0", gnt, 4'b0001);
      drive_pt();
      req = 4'b0010;
      sample_pt();
      check("late_issue_gnt", gnt, 4'b0000);
      drive_pt();
      sample_pt();
      check("late_resp_gnt", gnt, 4'b0000);
      check("late_resp_valid", rsp_valid, 4'b0001);
      drive_pt();
      sample_pt();
      check("late_gnt1", gnt, 4'b0010);

      // reset asserted during ISSUE of requester 1 aborts the op
      drive_pt();
      req = 4'b0000;
      check("abort_in_issue", alu_en, 1'b1);
      rst_n = 1'b0;
      drive_pt();
      sample_pt();
      check("abort_rsp_valid", rsp_valid, 4'b0000);
      check("abort_alu_en", alu_en, 1'b0);
      check("abort_busy", busy, 1'b0);
      check("abort_result", rsp_result, 32'd0);
      check("abort_alu_op1", alu_op1, 32'd0);
      drive_pt();
      rst_n = 1'b1;
      req = 4'b1010;
      sample_pt();
      check("abort_first_gnt", gnt, 4'b0010);
      drive_pt();
      req = 4'b0000;
      drive_pt();
      sample_pt();
      check("abort_next_valid", rsp_valid, 4'b0010);

      // requester 3: carry-out of all-ones + 1, then 0 + 0 with carry-in
      do_reset();
      req = 4'b1000;
      req_cin = 4'b0000;
      req_opcode[3*OPCODE +: OPCODE] = 4'b0000;
      req_op1[3*WIDTH +: WIDTH] = 32'hFFFF_FFFF;
      req_op2[3*WIDTH +: WIDTH] = 32'd1;
      sample_pt();
      check("cc_gnt_a", gnt, 4'b1000);
      drive_pt();
      req_opcode[3*OPCODE +: OPCODE] = 4'b0001;
      req_op1[3*WIDTH +: WIDTH] = 32'd0;
      req_op2[3*WIDTH +: WIDTH] = 32'd0;
      drive_pt();
      sample_pt();
      check("cc_result_a", rsp_result, 32'd0);
      check("cc_flags_a", rsp_flags, 4'b0011);
      drive_pt();
      sample_pt();
      check("cc_gnt_b", gnt, 4'b1000);
      drive_pt();
      req = 4'b0000;
      sample_pt();
`ifdef ALU_SCHEDULER_CARRY_CHAIN_EN
      carry_exp = 1'b1;
`else
      carry_exp = 1'b0;
`endif
      check("cc_alu_cin", alu_cin, carry_exp);
      check("cc_alu_opcode", alu_opcode, 4'b0001);
      check("cc_alu_op2_zero", alu_op2, 32'd0);
      drive_pt();
      sample_pt();
      check("cc_result_b", rsp_result, {31'd0, carry_exp});
      check("cc_valid_b", rsp_valid, 4'b1000);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/alu_scheduler.md
ALU_SCHEDULER -- requirements
Module: alu_scheduler

Interface
REQ-001 SHALL have parameters: WIDTH, 32, operand/result width; OPCODE, 4, opcode width; REGS_CODING, 3, destination code width; FLAGS, 4, flag width; CARRY, 0, carry flag bit index.
REQ-002 SHALL have ports: clk  in  1  single clock, all state on rising edge; rst_n  in  1  synchronous active-low reset.
REQ-003 SHALL have ports: req  in  4  per-requester request; req_opcode  in  4*OPCODE  packed opcodes, requester i at [i*OPCODE +: OPCODE]; req_op1, req_op2  in  4*WIDTH  packed operands; req_dest  in  4*REGS_CODING  packed destinations; req_cin  in  4  per-requester carry-in.
REQ-004 SHALL have ports: gnt  out  4  one-hot acceptance pulse; rsp_valid  out  4  one-hot completion pulse; rsp_result  out  WIDTH; rsp_flags  out  FLAGS; rsp_dest  out  REGS_CODING; busy  out  1  high when not IDLE.
REQ-005 SHALL have ALU-side ports: alu_en  out  1; alu_opcode  out  OPCODE; alu_op1, alu_op2  out  WIDTH; alu_cin  out  1; alu_dest_in  out  REGS_CODING; alu_result  in  WIDTH; alu_flags  in  FLAGS; alu_dest_out  in  REGS_CODING.

Function
REQ-006 SHALL implement FSM IDLE -> ISSUE -> RESP -> IDLE, one cycle per state except IDLE (waits while req==0).
REQ-007 In IDLE with req!=0, SHALL pick one requester round-robin, search starting at (last_gnt+1) mod 4, pulse gnt[i] for that cycle, latch its opcode/op1/op2/dest/cin into issue registers, set last_gnt=i, go to ISSUE.
REQ-008 In ISSUE, SHALL drive alu_en=1 and ALU inputs from issue registers; alu_en SHALL be 0 in all other states; ALU inputs SHALL hold issue-register values in all states.
REQ-009 At the rising edge ending ISSUE, SHALL register alu_result, alu_flags, alu_dest_out into rsp_result/rsp_flags/rsp_dest (ALU updates on falling edge mid-ISSUE).
REQ-010 In RESP, SHALL assert rsp_valid[last_gnt] for exactly one cycle; rsp_result/flags/dest SHALL hold until next RESP.
REQ-011 Latency: gnt in cycle N, alu_en in N+1, rsp_valid in N+2; max throughput one op per 3 cycles; new grant possible in N+3.
REQ-012 req sampled only in IDLE; requests arriving in ISSUE/RESP SHALL wait; a req held high after its gnt SHALL count as a new request.
REQ-013 Simultaneous requests: all four high continuously SHALL be granted in order 0,1,2,3,0,...; no requester starved beyond 3 intervening grants.
REQ-014 Opcode/operand values SHALL pass unmodified (incl. op2=0 division); no illegal-opcode filtering.
REQ-015 gnt and rsp_valid SHALL never have more than one bit set.

Reset
REQ-016 rst_n low at a rising edge SHALL set state=IDLE, last_gnt=3, gnt=0, rsp_valid=0, alu_en=0, issue registers=0, rsp_result/flags/dest=0, busy=0.
REQ-017 Reset during ISSUE or RESP SHALL abort the op with no rsp_valid pulse; first grant after release goes to lowest-index active requester.

Configuration
REQ-018 Macro ALU_SCHEDULER_CARRY_CHAIN_EN: when defined, SHALL keep a 4-bit per-requester carry register, cleared by reset, updated from alu_flags[CARRY] at end of ISSUE for the issuing requester, and alu_cin SHALL come from that register (req_cin ignored).
REQ-019 When undefined, alu_cin SHALL be the latched req_cin of the granted requester and no carry register exists.

Verification
REQ-020 Single req[2], opcode 0000, op1=5, op2=7 -> gnt[2] cycle N, alu_en N+1, rsp_valid[2] N+2 with rsp_result=12, rsp_dest=req_dest[2].
REQ-021 req=4'b1111 held 12 cycles after reset -> gnt order 0,1,2,3, gnt spacing 3 cycles, rsp_valid mirrors gnt 2 cycles later.
REQ-022 req[1] asserted during ISSUE of requester 0 -> gnt[1] not before the cycle after RESP.
REQ-023 rst_n low in ISSUE cycle -> no rsp_valid, all outputs 0 next cycle, busy=0.
REQ-024 Macro defined, requester 3: opcode 0000 op1=32'hFFFFFFFF op2=1 then opcode 0001 op1=0 op2=0 -> second alu_cin=1, rsp_result=1; macro undefined with req_cin[3]=0 -> rsp_result=0.
